// File: rtl/imem_loader_if.sv
// Byte channel into the program loader: the source drives valid/data, the loader answers with ready.
interface imem_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes SYNC/LEN/data/CSUM frames into instruction memory,
// verifies the checksum and releases the core through cpu_run.
module imem_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [7:0]        SYNC_BYTE = 8'hA5,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [8:0]        remaining_reg, remaining_next;
    logic [ADDR_W-1:0] index_reg, index_next;
    logic [7:0]        sum_reg, sum_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        wdata_reg, wdata_next;
    logic              xfer;

    assign rx.rx_ready = (state_reg == S_IDLE) || (state_reg == S_LEN) ||
                         (state_reg == S_DATA) || (state_reg == S_CSUM);
    assign xfer        = rx.rx_valid && rx.rx_ready;

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    // Terminal states are only left through start or reset, so the status flags follow the state.
    assign cpu_run    = (state_reg == S_DONE);
    assign done       = (state_reg == S_DONE);
    assign err        = (state_reg == S_ERROR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            remaining_reg <= '0;
            index_reg     <= '0;
            sum_reg       <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= BASE_ADDR;
            wdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            index_reg     <= index_next;
            sum_reg       <= sum_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        index_next     = index_reg;
        sum_next       = sum_reg;
        we_next        = 1'b0;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;

        // start wins over a same-cycle transfer; that byte is simply dropped.
        if (start) begin
            state_next     = S_IDLE;
            remaining_next = '0;
            index_next     = '0;
            sum_next       = '0;
        end else if (xfer) begin
            case (state_reg)
                S_IDLE: begin
                    if (rx.rx_data == SYNC_BYTE) begin
                        state_next = S_LEN;
                        sum_next   = '0;
                    end
                end
                S_LEN: begin
                    // A length byte of zero encodes a full 256-byte frame.
                    remaining_next = (rx.rx_data == 8'h00) ? 9'd256 : {1'b0, rx.rx_data};
                    index_next     = '0;
                    state_next     = S_DATA;
                end
                S_DATA: begin
                    we_next        = 1'b1;
                    addr_next      = BASE_ADDR + index_reg;
                    wdata_next     = rx.rx_data;
                    sum_next       = sum_reg + rx.rx_data;
                    index_next     = index_reg + 1'b1;
                    remaining_next = remaining_reg - 9'd1;
                    if (remaining_reg == 9'd1) begin
                        state_next = S_CSUM;
                    end
                end
                S_CSUM: begin
                    state_next = (rx.rx_data == sum_reg) ? S_DONE : S_ERROR;
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

endmodule
